// File: rtl/pipe_pkg.sv
// Shared encodings and constants for the 8-bit pipeline writeback path.
package pipe_pkg;

  typedef enum logic [1:0] {
    SP_OP_NONE = 2'b00,
    SP_OP_PUSH = 2'b01,
    SP_OP_POP  = 2'b10,
    SP_OP_RSVD = 2'b11
  } sp_op_e;

  typedef enum logic [1:0] {
    WEN_NONE = 2'b00,
    WEN_GPR  = 2'b01,
    WEN_SP   = 2'b10,
    WEN_BOTH = 2'b11
  } wen_e;

  localparam logic [1:0] SP_ADDR  = 2'd3;
  localparam logic [7:0] SP_RESET = 8'h03;
  localparam int         CNT_W    = 16;

endpackage

// File: rtl/sp_tracker.sv
// Shadow stack pointer: computes the post-PUSH/POP SP and commits it alongside the register file.
module sp_tracker #(
  parameter logic [1:0] SP_ADDR  = pipe_pkg::SP_ADDR,
  parameter logic [7:0] SP_RESET = pipe_pkg::SP_RESET
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wb_valid,
  input  pipe_pkg::sp_op_e     sp_op,
  input  logic                 gpr_wr,
  input  logic [1:0]           gpr_dest,
  input  logic [7:0]           gpr_data,
  output logic                 sp_wr,
  output logic [7:0]           sp_next,
  output logic [7:0]           sp_shadow
);
  import pipe_pkg::*;

  logic [7:0] sp_calc;

  always_comb begin
    sp_wr   = 1'b0;
    sp_calc = sp_shadow;
    if (wb_valid && !reset) begin
      unique case (sp_op)
        SP_OP_PUSH: begin
          sp_wr   = 1'b1;
          sp_calc = sp_shadow - 8'd1;
        end
        SP_OP_POP: begin
          sp_wr   = 1'b1;
          sp_calc = sp_shadow + 8'd1;
        end
        default: ;
      endcase
    end
  end

  assign sp_next = reset ? SP_RESET : sp_calc;

  // A stack op beats an explicit R3 write in the same cycle, matching the register file.
  always_ff @(posedge clk) begin
    if (reset)
      sp_shadow <= SP_RESET;
    else if (sp_wr)
      sp_shadow <= sp_calc;
    else if (gpr_wr && gpr_dest == SP_ADDR)
      sp_shadow <= gpr_data;
  end

endmodule

// File: rtl/regfile_wb_unit.sv
// Writeback stage: WB pipeline register, writeback mux, register-file write port and EX bypass.
module regfile_wb_unit #(
  parameter logic [1:0] SP_ADDR  = pipe_pkg::SP_ADDR,
  parameter logic [7:0] SP_RESET = pipe_pkg::SP_RESET,
  parameter int         CNT_W    = pipe_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mem_valid,
  input  logic             mem_flush,
  input  logic             mem_reg_wr,
  input  logic [1:0]       mem_dest,
  input  logic             mem_from_load,
  input  logic [7:0]       mem_alu_result,
  input  logic [7:0]       mem_load_data,
  input  logic [1:0]       mem_sp_op,
  output logic [1:0]       reg_file_wen,
  output logic [1:0]       dest_addr,
  output logic [7:0]       data_in1,
  output logic [7:0]       data_in2,
  output logic             fwd_valid,
  output logic [1:0]       fwd_addr,
  output logic [7:0]       fwd_data,
  output logic             fwd_sp_valid,
  output logic [7:0]       fwd_sp_data,
  output logic [7:0]       sp_shadow,
  output logic [CNT_W-1:0] retire_cnt
);
  import pipe_pkg::*;

  logic       wb_valid;
  logic       wb_reg_wr;
  logic [1:0] wb_dest;
  logic       wb_from_load;
  logic [7:0] wb_alu_result;
  logic [7:0] wb_load_data;
  sp_op_e     wb_sp_op;

  logic       gpr_wen;
  logic       sp_wen;

  always_ff @(posedge clk) begin
    if (reset) begin
      wb_valid      <= 1'b0;
      wb_reg_wr     <= 1'b0;
      wb_dest       <= '0;
      wb_from_load  <= 1'b0;
      wb_alu_result <= '0;
      wb_load_data  <= '0;
      wb_sp_op      <= SP_OP_NONE;
    end else begin
      wb_valid      <= mem_valid & ~mem_flush;
      wb_reg_wr     <= mem_reg_wr;
      wb_dest       <= mem_dest;
      wb_from_load  <= mem_from_load;
      wb_alu_result <= mem_alu_result;
      wb_load_data  <= mem_load_data;
      wb_sp_op      <= sp_op_e'(mem_sp_op);
    end
  end

  // Outputs are masked while reset is high so an instruction already in WB cannot write.
  assign gpr_wen   = wb_valid & wb_reg_wr & ~reset;
  assign dest_addr = reset ? 2'd0 : wb_dest;
  assign data_in1  = reset ? 8'd0 : (wb_from_load ? wb_load_data : wb_alu_result);

  sp_tracker #(
    .SP_ADDR  (SP_ADDR),
    .SP_RESET (SP_RESET)
  ) u_sp_tracker (
    .clk       (clk),
    .reset     (reset),
    .wb_valid  (wb_valid),
    .sp_op     (wb_sp_op),
    .gpr_wr    (gpr_wen),
    .gpr_dest  (wb_dest),
    .gpr_data  (data_in1),
    .sp_wr     (sp_wen),
    .sp_next   (data_in2),
    .sp_shadow (sp_shadow)
  );

  assign reg_file_wen = {sp_wen, gpr_wen};
  assign fwd_valid    = gpr_wen;
  assign fwd_addr     = dest_addr;
  assign fwd_data     = data_in1;
  assign fwd_sp_valid = sp_wen;
  assign fwd_sp_data  = data_in2;

  always_ff @(posedge clk) begin
    if (reset)
      retire_cnt <= '0;
    else if (wb_valid && retire_cnt != {CNT_W{1'b1}})
      retire_cnt <= retire_cnt + 1'b1;
  end

endmodule

// File: tb/tb_regfile_wb_unit.sv
// Directed table-driven bench for regfile_wb_unit with hand-computed expectations.
module tb_regfile_wb_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_valid, mem_flush, mem_reg_wr, mem_from_load;
  logic [1:0]  mem_dest, mem_sp_op;
  logic [7:0]  mem_alu_result, mem_load_data;
  logic [1:0]  reg_file_wen, dest_addr, fwd_addr;
  logic [7:0]  data_in1, data_in2, fwd_data, fwd_sp_data, sp_shadow;
  logic        fwd_valid, fwd_sp_valid;
  logic [15:0] retire_cnt;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  regfile_wb_unit dut (
    .clk            (clk),
    .reset          (reset),
    .mem_valid      (mem_valid),
    .mem_flush      (mem_flush),
    .mem_reg_wr     (mem_reg_wr),
    .mem_dest       (mem_dest),
    .mem_from_load  (mem_from_load),
    .mem_alu_result (mem_alu_result),
    .mem_load_data  (mem_load_data),
    .mem_sp_op      (mem_sp_op),
    .reg_file_wen   (reg_file_wen),
    .dest_addr      (dest_addr),
    .data_in1       (data_in1),
    .data_in2       (data_in2),
    .fwd_valid      (fwd_valid),
    .fwd_addr       (fwd_addr),
    .fwd_data       (fwd_data),
    .fwd_sp_valid   (fwd_sp_valid),
    .fwd_sp_data    (fwd_sp_data),
    .sp_shadow      (sp_shadow),
    .retire_cnt     (retire_cnt)
  );

  typedef struct {
    logic        v, fl, wr;
    logic [1:0]  dest;
    logic        ld;
    logic [7:0]  alu, lddata;
    logic [1:0]  op;
    logic [1:0]  e_wen, e_dest;
    logic [7:0]  e_d1, e_d2, e_sp;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t vecs[15];

  task automatic applyStimulus(input vec_t t);
    mem_valid      = t.v;
    mem_flush      = t.fl;
    mem_reg_wr     = t.wr;
    mem_dest       = t.dest;
    mem_from_load  = t.ld;
    mem_alu_result = t.alu;
    mem_load_data  = t.lddata;
    mem_sp_op      = t.op;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic checkPort(input string tag, input logic [1:0] wen, input logic [1:0] da,
                           input logic [7:0] d1, input logic [7:0] d2);
    checkOutput({tag, ".wen"}, 32'(reg_file_wen), 32'(wen));
    checkOutput({tag, ".dest_addr"}, 32'(dest_addr), 32'(da));
    checkOutput({tag, ".data_in1"}, 32'(data_in1), 32'(d1));
    checkOutput({tag, ".data_in2"}, 32'(data_in2), 32'(d2));
    checkOutput({tag, ".fwd_valid"}, 32'(fwd_valid), 32'(wen[0]));
    checkOutput({tag, ".fwd_addr"}, 32'(fwd_addr), 32'(da));
    checkOutput({tag, ".fwd_data"}, 32'(fwd_data), 32'(d1));
    checkOutput({tag, ".fwd_sp_valid"}, 32'(fwd_sp_valid), 32'(wen[1]));
    checkOutput({tag, ".fwd_sp_data"}, 32'(fwd_sp_data), 32'(d2));
  endtask

  initial begin
    vec_t idle;
    idle = '{1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 8'h00, 8'h00, 2'b00,
             2'b00, 2'd0, 8'h00, 8'h00, 8'h00, 16'd0};

    // v fl wr dest ld alu lddata op | wen dest d1 d2 sp(before commit) cnt
    vecs[0]  = '{0,0,0,2'd0,0,8'h00,8'h00,2'b00, 2'b00,2'd0,8'h00,8'h03,8'h03,16'd0};
    vecs[1]  = '{1,0,1,2'd1,0,8'h5A,8'h00,2'b00, 2'b01,2'd1,8'h5A,8'h03,8'h03,16'd0};
    vecs[2]  = '{1,0,0,2'd0,0,8'h00,8'h00,2'b01, 2'b10,2'd0,8'h00,8'h02,8'h03,16'd1};
    vecs[3]  = '{1,0,0,2'd0,0,8'h00,8'h00,2'b01, 2'b10,2'd0,8'h00,8'h01,8'h02,16'd2};
    vecs[4]  = '{1,0,0,2'd0,0,8'h00,8'h00,2'b01, 2'b10,2'd0,8'h00,8'h00,8'h01,16'd3};
    vecs[5]  = '{1,0,0,2'd0,0,8'h00,8'h00,2'b01, 2'b10,2'd0,8'h00,8'hFF,8'h00,16'd4};
    vecs[6]  = '{1,0,0,2'd0,0,8'h00,8'h00,2'b10, 2'b10,2'd0,8'h00,8'h00,8'hFF,16'd5};
    vecs[7]  = '{1,1,1,2'd2,0,8'h99,8'h00,2'b01, 2'b00,2'd2,8'h99,8'h00,8'h00,16'd6};
    vecs[8]  = '{1,0,0,2'd0,0,8'h00,8'h00,2'b11, 2'b00,2'd0,8'h00,8'h00,8'h00,16'd6};
    vecs[9]  = '{1,0,1,2'd3,0,8'h03,8'h00,2'b00, 2'b01,2'd3,8'h03,8'h00,8'h00,16'd7};
    vecs[10] = '{1,0,1,2'd2,1,8'h11,8'hC3,2'b10, 2'b11,2'd2,8'hC3,8'h04,8'h03,16'd8};
    vecs[11] = '{1,0,1,2'd3,0,8'h10,8'h00,2'b00, 2'b01,2'd3,8'h10,8'h04,8'h04,16'd9};
    vecs[12] = '{1,0,1,2'd3,0,8'h77,8'h00,2'b01, 2'b11,2'd3,8'h77,8'h0F,8'h10,16'd10};
    vecs[13] = '{1,0,1,2'd3,0,8'h20,8'h00,2'b00, 2'b01,2'd3,8'h20,8'h0F,8'h0F,16'd11};
    vecs[14] = '{0,0,0,2'd0,0,8'h00,8'h00,2'b00, 2'b00,2'd0,8'h00,8'h20,8'h20,16'd12};

    reset = 1'b1;
    applyStimulus(idle);
    repeat (2) @(posedge clk);
    #1;
    checkPort("reset", 2'b00, 2'd0, 8'h00, 8'h03);
    checkOutput("reset.sp_shadow", 32'(sp_shadow), 32'h03);
    checkOutput("reset.retire_cnt", 32'(retire_cnt), 32'd0);

    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 15; i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      applyStimulus(vecs[i]);
      @(posedge clk);
      #1;
      checkPort(tag, vecs[i].e_wen, vecs[i].e_dest, vecs[i].e_d1, vecs[i].e_d2);
      checkOutput({tag, ".sp_shadow"}, 32'(sp_shadow), 32'(vecs[i].e_sp));
      checkOutput({tag, ".retire_cnt"}, 32'(retire_cnt), 32'(vecs[i].e_cnt));
      @(negedge clk);
    end

    // Push lands in WB, then reset is raised while it is still there.
    applyStimulus('{1,0,0,2'd0,0,8'h00,8'h00,2'b01, 2'b10,2'd0,8'h00,8'h1F,8'h20,16'd0});
    @(posedge clk);
    #1;
    checkPort("push_before_reset", 2'b10, 2'd0, 8'h00, 8'h1F);
    checkOutput("push_before_reset.sp_shadow", 32'(sp_shadow), 32'h20);
    @(negedge clk);
    reset = 1'b1;
    applyStimulus(idle);
    #1;
    checkPort("reset_mid_push", 2'b00, 2'd0, 8'h00, 8'h03);
    @(posedge clk);
    #1;
    checkOutput("reset_mid_push.sp_shadow", 32'(sp_shadow), 32'h03);
    checkOutput("reset_mid_push.retire_cnt", 32'(retire_cnt), 32'd0);
    checkPort("reset_held", 2'b00, 2'd0, 8'h00, 8'h03);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    checkPort("after_reset", 2'b00, 2'd0, 8'h00, 8'h03);
    checkOutput("after_reset.sp_shadow", 32'(sp_shadow), 32'h03);
    checkOutput("after_reset.retire_cnt", 32'(retire_cnt), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/regfile_wb_unit.md
Name: regfile_wb_unit

Overview:
Writeback stage of the 8-bit pipeline. It registers the MEM-stage result, selects the writeback data, and performs the stack-pointer arithmetic for PUSH/POP. It drives the register file's write port (reg_file_wen, dest_addr, data_in1, data_in2), keeps a shadow SP so back-to-back stack ops never see a stale SP, and exports bypass values to EX.

Parameters:
SP_ADDR, 2'd3, register index used as stack pointer
SP_RESET, 8'h03, SP value after reset; equals the register file's reset value of R3
CNT_W, 16, width of the retired-instruction counter

Ports:
clk  input  1  clock, all state updates on posedge
reset  input  1  synchronous, active-high
mem_valid  input  1  MEM stage holds a real instruction
mem_flush  input  1  kill the instruction entering WB this cycle
mem_reg_wr  input  1  instruction writes a general register
mem_dest  input  2  destination register index
mem_from_load  input  1  1 = write load data, 0 = write ALU result
mem_alu_result  input  8  ALU result
mem_load_data  input  8  data-memory read value
mem_sp_op  input  2  00 none, 01 push (SP-1), 10 pop (SP+1), 11 reserved (treated as none)
reg_file_wen  output  2  01 gpr only, 10 SP only, 11 both, 00 none
dest_addr  output  2  write address for data_in1
data_in1  output  8  general write data
data_in2  output  8  new SP value
fwd_valid  output  1  WB writes a general register this cycle
fwd_addr  output  2  bypass address
fwd_data  output  8  bypass data (equals data_in1)
fwd_sp_valid  output  1  WB updates SP this cycle
fwd_sp_data  output  8  bypass SP value (equals data_in2)
sp_shadow  output  8  committed SP value
retire_cnt  output  CNT_W  count of retired valid instructions

Behaviour:
- WB pipeline register: on every posedge captures wb_valid <= mem_valid & ~mem_flush, plus reg_wr, dest, from_load, alu_result, load_data, sp_op. The stage never stalls.
- Latency: exactly one cycle from mem_* inputs to the write-port outputs.
- All write-port and bypass outputs are combinational from the WB register and the shadow SP.
- wen[0] = wb_valid & wb_reg_wr.
- wen[1] = wb_valid & (sp_op==01 | sp_op==10).
- data_in1 = from_load ? load_data : alu_result. dest_addr = wb_dest.
- data_in2: push gives sp_shadow-1 and pop gives sp_shadow+1, both 8-bit modulo (push at 00 gives FF; pop at FF gives 00). With no SP op, data_in2 = sp_shadow.
- Shadow SP update at the same posedge the register file commits:
  - If wen[1], sp_shadow <= data_in2.
  - Else if wen[0] and dest==SP_ADDR, sp_shadow <= data_in1 (explicit SP write).
  - Else sp_shadow holds.
- Conflict, wen==11 with dest==SP_ADDR: the register file's SP write wins, so sp_shadow takes data_in2. fwd_addr/fwd_data still report data_in1. EX bypass logic must give fwd_sp priority for R3. This is the decided behaviour.
- retire_cnt increments on each posedge with wb_valid=1 and saturates at all-ones.
- Reset (synchronous, wins over everything including mid-operation):
  - wb_valid=0 and all WB fields zero.
  - sp_shadow=SP_RESET, retire_cnt=0.
  - Therefore reg_file_wen=00, dest_addr=0, data_in1=0, data_in2=SP_RESET, fwd_valid=0, fwd_sp_valid=0 during and one cycle after reset. No write escapes in the cycle reset is asserted.
- Flush with mem_valid=1: a bubble is inserted and no write occurs. The counter does not increment.
- Reserved sp_op=11 behaves as 00.

Decomposition:
- Shared package pipe_pkg: SP_OP_NONE/PUSH/POP encodings, WEN_NONE/GPR/SP/BOTH encodings, SP_ADDR, SP_RESET.
- One natural sub-module: sp_tracker, which holds sp_shadow and computes next SP with modulo arithmetic and explicit-write handling.
- WB register and mux stay in the top module.

Test Plan:
- Reset held 2 cycles, then idle -> wen=00, data_in2=03, sp_shadow=03, retire_cnt=0.
- ALU write: mem_valid=1, reg_wr=1, dest=1, alu=5A -> next cycle wen=01, dest_addr=1, data_in1=5A, fwd_valid=1; after the edge retire_cnt=1.
- Three back-to-back pushes from SP=03 -> data_in2 = 02, 01, 00 on consecutive cycles with wen=10. Fourth push -> FF (wrap). Then pop -> 00.
- Pop with load to R2 (from_load=1, load=C3, sp_op=10) at SP=03 -> wen=11, dest_addr=2, data_in1=C3, data_in2=04.
- Conflict: reg_wr=1, dest=3, alu=77, push at SP=10 -> wen=11, data_in1=77, data_in2=0F; sp_shadow becomes 0F. Follow with plain write dest=3, alu=20 -> sp_shadow=20.
- Flush and reset mid-stream: valid write with mem_flush=1 -> wen=00, counter unchanged. Reset asserted while a push sits in WB -> no write that cycle, sp_shadow=03.
